// File: rtl/onehot_enc_pkg.sv
// Shared constants and the reference encode function for the one-hot code encoder.
package onehot_enc_pkg;

  localparam int ERRCNT_W   = 16;
  localparam int MAX_VEC_W  = 254;
  localparam int RAW_CODE_W = 8;

  // Returns {err, code}; callers zero-pad vec above their own width.
  function automatic logic [RAW_CODE_W:0] onehot_to_code(
    input logic [MAX_VEC_W-1:0] vec,
    input logic                 prio
  );
    logic [RAW_CODE_W-1:0] code;
    logic                  found;
    logic                  multi;
    code  = '0;
    found = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < MAX_VEC_W; i++) begin
      if (vec[i]) begin
        if (!found) begin
          code  = RAW_CODE_W'(i + 1);
          found = 1'b1;
        end else begin
          multi = 1'b1;
        end
      end
    end
    if (!found || (multi && !prio)) begin
      return {1'b1, {RAW_CODE_W{1'b0}}};
    end
    return {1'b0, code};
  endfunction

endpackage

// File: rtl/onehot_enc_core.sv
// Combinational encode: WIDTH-bit select vector to code, with INVALID_CODE substitution.
module onehot_enc_core
  import onehot_enc_pkg::*;
#(
  parameter int                 WIDTH         = 10,
  parameter int                 CODE_W        = 8,
  parameter logic [CODE_W-1:0]  INVALID_CODE  = CODE_W'(8'h0F),
  parameter int                 PRIORITY_MODE = 0
) (
  input  logic [WIDTH-1:0]  vec,
  output logic [CODE_W-1:0] code,
  output logic              err
);

  logic [MAX_VEC_W-1:0]  padded;
  logic [RAW_CODE_W:0]   res;

  always_comb begin
    padded = '0;
    padded[WIDTH-1:0] = vec;
    res  = onehot_to_code(padded, (PRIORITY_MODE != 0));
    err  = res[RAW_CODE_W];
    code = err ? INVALID_CODE : CODE_W'(res[RAW_CODE_W-1:0]);
  end

endmodule

// File: rtl/onehot_code_enc.sv
// Registered one-hot to code encoder with valid/ready handshake.
// Optional saturating error counter enabled by ONEHOT_ENC_ERRCNT_EN.
module onehot_code_enc
  import onehot_enc_pkg::*;
#(
  parameter int                 WIDTH         = 10,
  parameter int                 CODE_W        = 8,
  parameter logic [CODE_W-1:0]  INVALID_CODE  = CODE_W'(8'h0F),
  parameter int                 PRIORITY_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    in_vec,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CODE_W-1:0]   out_code,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready
`ifdef ONEHOT_ENC_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt,
  input  logic                err_clr
`endif
);

  logic [CODE_W-1:0] enc_code;
  logic              enc_err;
  logic              accept;
  logic              complete;

  onehot_enc_core #(
    .WIDTH         (WIDTH),
    .CODE_W        (CODE_W),
    .INVALID_CODE  (INVALID_CODE),
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_core (
    .vec  (in_vec),
    .code (enc_code),
    .err  (enc_err)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign complete = out_valid && out_ready;

  // Accept takes precedence so a simultaneous complete+accept keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_code  <= INVALID_CODE;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_code  <= enc_code;
      out_err   <= enc_err;
    end else if (complete) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ONEHOT_ENC_ERRCNT_EN
  // Clear beats a same-cycle invalid accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (accept && enc_err && (err_cnt != {ERRCNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_onehot_code_enc.sv
// Self-checking bench: strict and priority instances fed identical randomized traffic.
module tb_onehot_code_enc;

  localparam int WIDTH = 10;

  typedef struct {
    logic [7:0] code_s;
    logic       err_s;
    logic [7:0] code_p;
    logic       err_p;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_vec;
  logic             in_valid;
  logic             out_ready;
  logic             in_ready_s, in_ready_p;
  logic [7:0]       out_code_s, out_code_p;
  logic             out_err_s, out_err_p;
  logic             out_valid_s, out_valid_p;
`ifdef ONEHOT_ENC_ERRCNT_EN
  logic [15:0]      err_cnt_s, err_cnt_p;
  logic             err_clr;
  int unsigned      cnt_s, cnt_p;
`endif

  int   test_count = 0;
  int   fail_count = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  onehot_code_enc #(.WIDTH(WIDTH), .CODE_W(8), .INVALID_CODE(8'h0F), .PRIORITY_MODE(0)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .out_code  (out_code_s),
    .out_err   (out_err_s),
    .out_valid (out_valid_s),
    .out_ready (out_ready)
`ifdef ONEHOT_ENC_ERRCNT_EN
    ,
    .err_cnt   (err_cnt_s),
    .err_clr   (err_clr)
`endif
  );

  onehot_code_enc #(.WIDTH(WIDTH), .CODE_W(8), .INVALID_CODE(8'h0F), .PRIORITY_MODE(1)) dut_p (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready_p),
    .out_code  (out_code_p),
    .out_err   (out_err_p),
    .out_valid (out_valid_p),
    .out_ready (out_ready)
`ifdef ONEHOT_ENC_ERRCNT_EN
    ,
    .err_cnt   (err_cnt_p),
    .err_clr   (err_clr)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Lowest set bit isolated arithmetically, then located with $clog2.
  function automatic void modelEnc(input logic [WIDTH-1:0] v, input bit prio,
                                   output logic [7:0] code, output logic err);
    logic [WIDTH-1:0] low;
    if (v == '0 || (!prio && $countones(v) != 1)) begin
      code = 8'h0F;
      err  = 1'b1;
    end else begin
      low  = v & (~v + 1'b1);
      code = 8'($clog2(low) + 1);
      err  = 1'b0;
    end
  endfunction

  // One clock cycle: drive after negedge, check before and after the posedge.
  task automatic applyStimulus(input logic [WIDTH-1:0] vec, input logic valid, input logic ready);
    logic exp_ready, acc, comp;
    exp_t e;
    in_vec    = vec;
    in_valid  = valid;
    out_ready = ready;
    #1;
    exp_ready = (q.size() == 0) || ready;
    checkOutput("in_ready_s", in_ready_s, exp_ready);
    checkOutput("in_ready_p", in_ready_p, exp_ready);
    if (q.size() > 0) begin
      checkOutput("out_code_s", out_code_s, q[0].code_s);
      checkOutput("out_err_s", out_err_s, q[0].err_s);
      checkOutput("out_code_p", out_code_p, q[0].code_p);
      checkOutput("out_err_p", out_err_p, q[0].err_p);
    end
    acc  = valid && exp_ready;
    comp = (q.size() > 0) && ready;
    modelEnc(vec, 1'b0, e.code_s, e.err_s);
    modelEnc(vec, 1'b1, e.code_p, e.err_p);
    @(posedge clk);
    #1;
    if (comp) void'(q.pop_front());
    if (acc) q.push_back(e);
`ifdef ONEHOT_ENC_ERRCNT_EN
    if (err_clr) begin
      cnt_s = 0;
      cnt_p = 0;
    end else if (acc) begin
      if (e.err_s && cnt_s < 65535) cnt_s++;
      if (e.err_p && cnt_p < 65535) cnt_p++;
    end
    checkOutput("err_cnt_s", err_cnt_s, cnt_s);
    checkOutput("err_cnt_p", err_cnt_p, cnt_p);
`endif
    checkOutput("out_valid_s", out_valid_s, q.size() > 0);
    checkOutput("out_valid_p", out_valid_p, q.size() > 0);
    @(negedge clk);
  endtask

  function automatic logic [WIDTH-1:0] randVec();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel < 5) return WIDTH'(1) << $urandom_range(0, WIDTH - 1);
    if (sel == 5) return '0;
    return WIDTH'($urandom);
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_vec    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef ONEHOT_ENC_ERRCNT_EN
    err_clr = 1'b0;
    cnt_s   = 0;
    cnt_p   = 0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", out_valid_s, 1'b0);
    checkOutput("rst_out_code", out_code_s, 8'h0F);
    checkOutput("rst_out_err", out_err_s, 1'b0);
    checkOutput("rst_in_ready", in_ready_s, 1'b1);
    checkOutput("rst_out_code_p", out_code_p, 8'h0F);
`ifdef ONEHOT_ENC_ERRCNT_EN
    checkOutput("rst_err_cnt", err_cnt_s, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors from the bring-up list.
    applyStimulus(10'b00_0000_0100, 1'b1, 1'b1);
    checkOutput("dir_code3", out_code_s, 8'd3);
    applyStimulus(10'b00_0001_0010, 1'b1, 1'b1);
    checkOutput("dir_multi_s", out_code_s, 8'h0F);
    checkOutput("dir_multi_p", out_code_p, 8'd2);
    applyStimulus(10'b00_0000_0000, 1'b1, 1'b1);
    checkOutput("dir_zero_p_err", out_err_p, 1'b1);
    applyStimulus(10'b10_0000_0000, 1'b1, 1'b1);
    checkOutput("dir_top_bit", out_code_s, 8'd10);
    applyStimulus('0, 1'b0, 1'b1);

    // Back-pressure hold, then release with a new word in the same cycle.
    applyStimulus(10'b00_0010_0000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(randVec(), 1'b1, 1'b0);
    checkOutput("hold_code", out_code_s, 8'd6);
    applyStimulus(10'b00_0000_0001, 1'b1, 1'b1);
    checkOutput("release_code", out_code_s, 8'd1);

    // Back-to-back stream, bits 0..9.
    for (int i = 0; i < WIDTH; i++) applyStimulus(WIDTH'(1) << i, 1'b1, 1'b1);
    applyStimulus('0, 1'b0, 1'b1);

    // Randomized traffic with random stalls.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(randVec(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    applyStimulus('0, 1'b0, 1'b1);

`ifdef ONEHOT_ENC_ERRCNT_EN
    // Clear wins over a same-cycle invalid accept.
    err_clr = 1'b1;
    applyStimulus('0, 1'b1, 1'b1);
    err_clr = 1'b0;
    // Saturation from a preset value.
    force dut_s.err_cnt = 16'hFFFE;
    force dut_p.err_cnt = 16'hFFFE;
    #1;
    release dut_s.err_cnt;
    release dut_p.err_cnt;
    cnt_s = 32'hFFFE;
    cnt_p = 32'hFFFE;
    for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1, 1'b1);
    checkOutput("sat_err_cnt", err_cnt_s, 16'hFFFF);
`endif

    // Asynchronous reset with a word held in the output register.
    applyStimulus(10'b00_0100_0000, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid_s", out_valid_s, 1'b0);
    checkOutput("async_rst_valid_p", out_valid_p, 1'b0);
`ifdef ONEHOT_ENC_ERRCNT_EN
    checkOutput("async_rst_err_cnt", err_cnt_s, 0);
    cnt_s = 0;
    cnt_p = 0;
`endif
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(randVec(), 1'b1, 1'($urandom_range(0, 1)));
    applyStimulus('0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
